// File: rtl/serial_pattern_detector.sv
// rtl/serial_pattern_detector.sv - N-channel serial pattern detector with match hold-off
// Define MATCH_CNT_EN to add per-channel saturating match counters on match_cnt.
module serial_pattern_detector #(
  parameter int               N_CH    = 2,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               HOLDOFF = 2,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CH-1:0]   LINEA,
  input  logic [N_CH-1:0]   LINEA_VLD,
  output logic [N_CH-1:0]   U,
`ifdef MATCH_CNT_EN
  output logic [8*N_CH-1:0] match_cnt,
`endif
  output logic              prop
);

  typedef enum logic [1:0] {S_FILL, S_ARMED, S_HOLD} state_t;

  localparam int             FW        = $clog2(PAT_W);
  localparam logic [FW-1:0]  FILL_LAST = FW'(PAT_W - 1);
  localparam logic [7:0]     HOLD_INIT = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

  logic [N_CH-1:0] ch_ok;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t           st;
    logic [PAT_W-1:0] sr;
    logic [FW-1:0]    fill;
    logic [7:0]       hcnt;
    logic             u_q;
    logic             u_prev;
    logic [PAT_W-1:0] w;
    logic             take;

    // Window including the bit being offered this cycle; the oldest sr bit falls off.
    assign w    = PAT_W'({sr, LINEA[c]});
    assign take = (w == PATTERN) &&
                  ((st == S_ARMED) || ((st == S_FILL) && (fill == FILL_LAST)));

    always_ff @(posedge clock) begin
      if (reset) begin
        st     <= S_FILL;
        sr     <= '0;
        fill   <= '0;
        hcnt   <= '0;
        u_q    <= 1'b0;
        u_prev <= 1'b0;
      end else begin
        u_prev <= u_q;
        u_q    <= 1'b0;
        if (LINEA_VLD[c]) begin
          sr <= w;
          if (take) begin
            u_q  <= 1'b1;
            fill <= '0;
            if (HOLDOFF > 0) begin
              st   <= S_HOLD;
              hcnt <= HOLD_INIT;
            end else if (OVERLAP) begin
              st <= S_ARMED;
            end else begin
              st <= S_FILL;
            end
          end else begin
            case (st)
              S_FILL: begin
                if (fill == FILL_LAST) begin
                  st   <= S_ARMED;
                  fill <= '0;
                end else begin
                  fill <= fill + 1'b1;
                end
              end
              S_ARMED: st <= S_ARMED;
              S_HOLD: begin
                if (hcnt == 8'd0) begin
                  // Non-overlap flush: a fresh PAT_W bits must arrive before the next match.
                  if (OVERLAP) begin
                    st <= S_ARMED;
                  end else begin
                    st   <= S_FILL;
                    fill <= '0;
                  end
                end else begin
                  hcnt <= hcnt - 1'b1;
                end
              end
              default: st <= S_FILL;
            endcase
          end
        end
      end
    end

    assign U[c] = u_q;
    assign ch_ok[c] = !u_q ||
                      (((st == S_HOLD) ||
                        ((HOLDOFF == 0) && ((st == S_ARMED) || (st == S_FILL)))) &&
                       ((HOLDOFF == 0) || !u_prev));

`ifdef MATCH_CNT_EN
    logic [7:0] mcnt;
    always_ff @(posedge clock) begin
      if (reset) begin
        mcnt <= '0;
      end else if (u_q && (mcnt != 8'hFF)) begin
        mcnt <= mcnt + 8'd1;
      end
    end
    assign match_cnt[8*c +: 8] = mcnt;
`endif
  end

  assign prop = &ch_ok;

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (prop);
    end
  end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb/tb_serial_pattern_detector.sv - directed-vector bench for serial_pattern_detector
module tb_serial_pattern_detector;

  logic       clock;
  logic       reset;
  logic [1:0] lin;
  logic [1:0] vld;
  logic [1:0] u_a, u_b, u_c, u_d, u_e;
  logic       p_a, p_b, p_c, p_d, p_e;
  logic [1:0] u_sel;
  int         sel;
  int         errors;
  int         checks;
`ifdef MATCH_CNT_EN
  logic [15:0] mc_a, mc_b, mc_c, mc_d, mc_e;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // a: defaults, b: no hold-off, c: no hold-off non-overlap, d: all-ones no hold-off, e: all-ones hold-off 2
  serial_pattern_detector #(.N_CH(2), .PAT_W(4), .PATTERN(4'b1011), .HOLDOFF(2), .OVERLAP(1'b1)) dut_a (
    .clock(clock), .reset(reset), .LINEA(lin), .LINEA_VLD(vld), .U(u_a),
`ifdef MATCH_CNT_EN
    .match_cnt(mc_a),
`endif
    .prop(p_a));
  serial_pattern_detector #(.N_CH(2), .PAT_W(4), .PATTERN(4'b1011), .HOLDOFF(0), .OVERLAP(1'b1)) dut_b (
    .clock(clock), .reset(reset), .LINEA(lin), .LINEA_VLD(vld), .U(u_b),
`ifdef MATCH_CNT_EN
    .match_cnt(mc_b),
`endif
    .prop(p_b));
  serial_pattern_detector #(.N_CH(2), .PAT_W(4), .PATTERN(4'b1011), .HOLDOFF(0), .OVERLAP(1'b0)) dut_c (
    .clock(clock), .reset(reset), .LINEA(lin), .LINEA_VLD(vld), .U(u_c),
`ifdef MATCH_CNT_EN
    .match_cnt(mc_c),
`endif
    .prop(p_c));
  serial_pattern_detector #(.N_CH(2), .PAT_W(4), .PATTERN(4'b1111), .HOLDOFF(0), .OVERLAP(1'b1)) dut_d (
    .clock(clock), .reset(reset), .LINEA(lin), .LINEA_VLD(vld), .U(u_d),
`ifdef MATCH_CNT_EN
    .match_cnt(mc_d),
`endif
    .prop(p_d));
  serial_pattern_detector #(.N_CH(2), .PAT_W(4), .PATTERN(4'b1111), .HOLDOFF(2), .OVERLAP(1'b1)) dut_e (
    .clock(clock), .reset(reset), .LINEA(lin), .LINEA_VLD(vld), .U(u_e),
`ifdef MATCH_CNT_EN
    .match_cnt(mc_e),
`endif
    .prop(p_e));

  always_comb begin
    u_sel = '0;
    case (sel)
      0:       u_sel = u_a;
      1:       u_sel = u_b;
      2:       u_sel = u_c;
      3:       u_sel = u_d;
      default: u_sel = u_e;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] d, input logic [1:0] v, input logic [1:0] exp_u,
                      input string tag);
    lin = d;
    vld = v;
    @(posedge clock);
    #1;
    check(tag, u_sel, exp_u);
    check({tag, "_prop"}, {p_a, p_b, p_c, p_d, p_e}, 5'b11111);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    lin   = 2'b11;
    vld   = 2'b11;
    @(posedge clock);
    #1;
    check(tag, {u_a, u_b, u_c, u_d, u_e}, 10'd0);
    reset = 1'b0;
  endtask

  // Channel 0 only; bits[n-1] is sent first, expv[k] is the U[0] expected after that bit.
  task automatic run_stream(input int n, input logic [31:0] bits, input logic [31:0] expv,
                            input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step({bits[i], bits[i]}, 2'b01, {1'b0, expv[i]}, $sformatf("%s[%0d]", tag, n - i));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sel    = 0;
    reset  = 1'b1;
    lin    = '0;
    vld    = '0;

    do_reset("reset_state");

    sel = 0;
    run_stream(4, 32'b1011, 32'b0001, "t1_basic");

    do_reset("rst_t2a");
    run_stream(7, 32'b1011011, 32'b0001001, "t2_hold2");

    sel = 1;
    do_reset("rst_t2b");
    run_stream(10, 32'b1011011011, 32'b0001001001, "t2_hold0");

    sel = 2;
    do_reset("rst_t3a");
    run_stream(7, 32'b1011011, 32'b0001000, "t3_novl_a");
    do_reset("rst_t3b");
    run_stream(8, 32'b10111011, 32'b00010001, "t3_novl_b");

    do_reset("rst_ch1");
    begin
      logic [3:0] pat;
      pat = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        step({pat[i], 1'b1}, 2'b10, (i == 0) ? 2'b10 : 2'b00, $sformatf("ch1[%0d]", 4 - i));
      end
    end

    sel = 0;
    do_reset("rst_t4");
    begin
      logic [3:0] pat;
      pat = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        step({1'b0, pat[i]}, 2'b01, (i == 0) ? 2'b01 : 2'b00, $sformatf("t4_bit[%0d]", 4 - i));
        for (int g = 0; g < 3; g++) begin
          step({pat[i], ~pat[i]}, 2'b00, 2'b00, $sformatf("t4_gap[%0d.%0d]", 4 - i, g));
        end
      end
    end

    do_reset("rst_t5");
    run_stream(3, 32'b101, 32'b000, "t5_pre");
    do_reset("rst_t5_mid");
    run_stream(5, 32'b11011, 32'b00001, "t5_post");

    sel = 4;
    do_reset("rst_e");
    run_stream(10, 32'b1111111111, 32'b0001001001, "e_hold_ones");

    sel = 3;
    do_reset("rst_t6");
    for (int k = 1; k <= 300; k++) begin
      step(2'b01, 2'b01, (k >= 4) ? 2'b01 : 2'b00, $sformatf("t6_ones[%0d]", k));
`ifdef MATCH_CNT_EN
      if (k == 100) check("t6_cnt_mid", mc_d, 16'd96);
`endif
    end
`ifdef MATCH_CNT_EN
    check("t6_cnt_sat", mc_d, 16'd255);
    check("t6_cnt_e", mc_e, 16'd99);
    check("t6_cnt_zero", {mc_a, mc_b, mc_c}, 48'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
